// File: rtl/fdiv_pkg.sv
// Shared types and constants for the iterative divide mantissa path.
package fdiv_pkg;

    localparam int ITER   = 26;
    localparam int MANT_W = 24;
    localparam int SA_W   = 5;

    typedef enum logic [2:0] {
        IDLE,
        NORM_A,
        NORM_B,
        DIV,
        DONE
    } fdiv_state_t;

endpackage

// File: rtl/shift_to_msb_equ_1.sv
// Leading-one normalizer: shifts the significand left until bit 23 is set.
module shift_to_msb_equ_1
    import fdiv_pkg::*;
(
    input  logic [MANT_W-1:0] a,
    output logic [MANT_W-1:0] a_shifted,
    output logic [SA_W-1:0]   sa
);

    // Zero input reports 31, which is not a meaningful shift count.
    always_comb begin
        sa = '1;
        for (int i = 0; i < MANT_W; i++) begin
            if (a[i]) sa = SA_W'(MANT_W - 1 - i);
        end
        a_shifted = a << sa;
    end

endmodule

// File: rtl/fdiv_mant_seq.sv
// Normalizes both significands through one shared normalizer, then runs a
// restoring divide producing ITER quotient bits MSB first plus a sticky bit.
module fdiv_mant_seq
    import fdiv_pkg::*;
#(
    parameter int ITER = fdiv_pkg::ITER
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic [23:0] a_mant,
    input  logic [23:0] b_mant,
    output logic        ready,
    output logic        done,
    output logic [25:0] q,
    output logic        sticky,
    output logic [4:0]  sa_a,
    output logic [4:0]  sa_b,
    output logic        a_zero,
    output logic        div_by_zero
);

    // Handshake: a request is taken on the rising edge where start && ready;
    // start while busy is dropped, never queued. done pulses for one cycle.

    fdiv_state_t       state_q, state_d;
    logic [MANT_W-1:0] a_reg, b_reg;
    logic [MANT_W:0]   r;
    logic [SA_W-1:0]   cnt;

    logic [MANT_W-1:0] norm_in, norm_out;
    logic [SA_W-1:0]   norm_sa;
    logic              rem_ge;
    logic [MANT_W:0]   rem_pre;

    assign norm_in = (state_q == NORM_A) ? a_reg : b_reg;

    shift_to_msb_equ_1 u_norm (
        .a         (norm_in),
        .a_shifted (norm_out),
        .sa        (norm_sa)
    );

    assign rem_ge  = (r >= {1'b0, b_reg});
    assign rem_pre = rem_ge ? (r - {1'b0, b_reg}) : r;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) state_d = NORM_A;
            end
            NORM_A: state_d = NORM_B;
            // a_zero was registered in NORM_A; b_reg still holds the raw divisor.
            NORM_B: state_d = (a_zero || (b_reg == '0)) ? DONE : DIV;
            DIV: begin
                if (cnt == SA_W'(ITER - 1)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            a_reg       <= '0;
            b_reg       <= '0;
            r           <= '0;
            cnt         <= '0;
            q           <= '0;
            sticky      <= 1'b0;
            sa_a        <= '0;
            sa_b        <= '0;
            a_zero      <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_reg       <= a_mant;
                        b_reg       <= b_mant;
                        q           <= '0;
                        cnt         <= '0;
                        sticky      <= 1'b0;
                        a_zero      <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                NORM_A: begin
                    a_reg  <= norm_out;
                    sa_a   <= norm_sa;
                    a_zero <= (a_reg == '0);
                end
                NORM_B: begin
                    b_reg       <= norm_out;
                    sa_b        <= norm_sa;
                    div_by_zero <= (b_reg == '0);
                    r           <= {1'b0, a_reg};
                    cnt         <= '0;
                end
                DIV: begin
                    // r < 2*b keeps the shifted remainder inside 25 bits.
                    r   <= {rem_pre[MANT_W-1:0], 1'b0};
                    q   <= {q[24:0], rem_ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == SA_W'(ITER - 1)) sticky <= |rem_pre;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fdiv_mant_seq.md
# fdiv_mant_seq

Multi-cycle mantissa sequencer for the pipelined FPU's iterative divide path. It accepts two 24-bit significands, which may be unnormalized (subnormal operands). It normalizes both through a single shared leading-one normalizer, then runs a 26-iteration restoring division. It returns the quotient bits, a sticky bit and both shift amounts to the exponent/rounding stage. It sits between operand unpack and the fdiv round/pack logic, and frees the main pipeline from holding two normalizers.

## Interface
Parameters:
- ITER, 26, quotient bits produced: 1 integer, 23 fraction, guard, round.

Ports:
- clk  in  1  rising-edge clock
- clrn  in  1  asynchronous active-low reset
- start  in  1  request; accepted only while ready=1
- a_mant  in  24  dividend significand, hidden bit included, sampled on accepted start
- b_mant  in  24  divisor significand, same format
- ready  out  1  1 in IDLE, else 0
- done  out  1  one-cycle pulse; results valid
- q  out  26  quotient; q[25] integer bit, q[24:0] fraction
- sticky  out  1  OR of final remainder (inexact)
- sa_a  out  5  left-shift count applied to a_mant
- sa_b  out  5  left-shift count applied to b_mant
- a_zero  out  1  a_mant was 0
- div_by_zero  out  1  b_mant was 0

## Operation
- FSM states and transitions:
  - IDLE → NORM_A on start.
  - NORM_A → NORM_B.
  - NORM_B → DIV, or → DONE if the latched a or b is zero.
  - DIV → DONE after ITER cycles.
  - DONE → IDLE.
- IDLE: ready=1. On start, latch a_mant/b_mant into a_reg/b_reg, then go to NORM_A. Clear sticky, a_zero and div_by_zero at the same time.
- NORM_A:
  - Drive the shared normalizer with a_reg. Register the normalized value back into a_reg and the count into sa_a.
  - Set a_zero = (a_reg==0). A zero input yields sa_a=31 and must not be interpreted as a shift.
- NORM_B: same as NORM_A for b_reg/sa_b. Set div_by_zero = (b_reg==0).
- Normalizer input mux is selected by state (a_reg in NORM_A, b_reg otherwise). No other user of the instance.
- DIV:
  - Uses a 25-bit remainder r, initialized to {1'b0,a_reg} on NORM_B→DIV, and a 5-bit iteration counter cnt counting 0..ITER-1.
  - Each cycle: if r >= {1'b0,b_reg}, then r ← (r−b)<<1 and shift 1 into q LSB. Otherwise r ← r<<1 and shift 0 into q.
  - Quotient is built MSB first. Invariant: r < 2·b < 2^25, so no overflow.
- DONE:
  - done=1 for exactly this cycle. sticky = |r (the final-iteration remainder before the shift).
  - Zero or div-by-zero path: q=0, sticky=0.
- Outputs q, sticky, sa_a, sa_b, a_zero and div_by_zero hold their values from DONE until the next accepted start.
- start while ready=0 is ignored; no queueing.

## Timing
- Accepted start in cycle 0. NORM_A is cycle 1, NORM_B is cycle 2, DIV is cycles 3–28, done=1 in cycle 29, ready=1 again in cycle 30.
- Zero/div-by-zero path: done=1 in cycle 3.
- Back-to-back: start asserted in the cycle ready returns is accepted. Minimum issue interval is 30 cycles (4 on the zero path).
- Reset (clrn=0, asynchronous, any state including mid-DIV):
  - state=IDLE; cnt=0; ready=1; done=0.
  - q=0; r=0; sticky=0; sa_a=sa_b=0; a_zero=div_by_zero=0.
  - Any in-flight operation is discarded with no done pulse.
- Normalizer is purely combinational within the NORM cycle; its output must settle in one clk period.

## Structure
- Shared package fdiv_pkg holds:
  - the FSM state enum (IDLE, NORM_A, NORM_B, DIV, DONE);
  - the ITER constant;
  - the significand width of 24 and shift-count width of 5.
- One sub-module: the existing normalizer shift_to_msb_equ_1. Instantiate it exactly once (u_norm), time-shared between operands.
- Restoring-divide datapath (compare/subtract, r, q shift register, cnt) stays inline in fdiv_mant_seq.

## Test plan
- a=0x800000, b=0x800000 → done at cycle 29; q=0x2000000, sticky=0, sa_a=sa_b=0.
- a=0xC00000, b=0x800000 → q=0x3000000, sticky=0.
- a=0x800000, b=0xC00000 (2/3) → q=0x1555555, sticky=1.
- a=0x000001, b=0x400000 → sa_a=23, sa_b=1, q=0x2000000, sticky=0.
- b=0x000000 → div_by_zero=1, q=0, done at cycle 3. Separately, a=0 → a_zero=1, done at cycle 3.
- Assert start during DIV, then pull clrn low at cycle 10:
  - start is ignored while busy;
  - after reset, all outputs are zero, ready=1, and no done pulse occurs;
  - the next start completes normally.
